// File: rtl/biquad_cascade_sched_if.sv
// Sample, coefficient, MAC and output signals of the biquad cascade scheduler.
// The master modport is the scheduler side; the slave modport is its environment.
interface biquad_cascade_sched_if #(
    parameter int NUM_STAGES = 4
);
    localparam int ADDR_W = $clog2(NUM_STAGES * 5);

    logic                     sample_valid;
    logic                     sample_ch;
    logic signed [15:0]       sample_in;
    logic                     coef_we;
    logic        [ADDR_W-1:0] coef_addr;
    logic signed [15:0]       coef_wdata;
    logic                     coef_commit;
    logic signed [15:0]       mac_a;
    logic signed [15:0]       mac_b;
    logic                     mac_ce;
    logic                     mac_clr;
    logic signed [31:0]       mac_result;
    logic                     out_valid;
    logic                     out_ch;
    logic signed [15:0]       out_sample;
    logic                     busy;
    logic                     overrun;

    modport master (
        input  sample_valid, sample_ch, sample_in,
        input  coef_we, coef_addr, coef_wdata, coef_commit,
        input  mac_result,
        output mac_a, mac_b, mac_ce, mac_clr,
        output out_valid, out_ch, out_sample, busy, overrun
    );

    modport slave (
        output sample_valid, sample_ch, sample_in,
        output coef_we, coef_addr, coef_wdata, coef_commit,
        output mac_result,
        input  mac_a, mac_b, mac_ce, mac_clr,
        input  out_valid, out_ch, out_sample, busy, overrun
    );
endinterface

// File: rtl/biquad_cascade_sched.sv
// Time-shares one external 16x16 MAC over NUM_STAGES biquads for L/R channels.
// Define BIQUAD_SAT_EN to saturate each stage result instead of wrapping it.
module biquad_cascade_sched #(
    parameter int NUM_STAGES = 4,
    parameter int MAC_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    biquad_cascade_sched_if.master bus
);
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int NCOEF  = NUM_STAGES * 5;
    localparam int ADDR_W = $clog2(NCOEF);
    localparam int STG_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int DRN_W  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);
    localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(MAC_LAT - 1);
    localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(16384);

    typedef enum logic [2:0] { IDLE, ISSUE, DRAIN, WB, OUT } state_t;

    state_t                   state, state_nxt;
    logic [2:0]               op_cnt;
    logic [DRN_W-1:0]         drn_cnt;
    logic [STG_W-1:0]         stage;
    logic [ADDR_W-1:0]        cidx;
    logic                     ch_r;
    logic signed [DATA_W-1:0] x_cur;
    logic signed [DATA_W-1:0] y_last;
    logic signed [DATA_W-1:0] y_wb;

    logic signed [COEF_W-1:0] shadow     [NCOEF];
    logic signed [COEF_W-1:0] shadow_nxt [NCOEF];
    logic signed [COEF_W-1:0] active     [NCOEF];
    logic                     commit_pend;
    logic                     do_copy;

    logic signed [DATA_W-1:0] x1_h [2][NUM_STAGES];
    logic signed [DATA_W-1:0] x2_h [2][NUM_STAGES];
    logic signed [DATA_W-1:0] y1_h [2][NUM_STAGES];
    logic signed [DATA_W-1:0] y2_h [2][NUM_STAGES];

    logic                     out_valid_r;
    logic                     out_ch_r;
    logic signed [DATA_W-1:0] out_sample_r;
    logic                     overrun_r;

    // Feedback coefficients are negated on issue; the most negative value cannot be negated.
    function automatic logic signed [COEF_W-1:0] neg_sat(input logic signed [COEF_W-1:0] c);
        if (c == {1'b1, {(COEF_W-1){1'b0}}})
            neg_sat = {1'b0, {(COEF_W-1){1'b1}}};
        else
            neg_sat = -c;
    endfunction

    // Q2.14 coefficient times integer sample: drop the 14 fraction bits.
    function automatic logic signed [DATA_W-1:0] requant(input logic signed [31:0] acc);
        requant = acc[29:14];
`ifdef BIQUAD_SAT_EN
        if (acc[31:29] != {3{acc[31]}})
            requant = acc[31] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    endfunction

    assign cidx    = ADDR_W'(int'(stage) * 5 + int'(op_cnt));
    assign y_wb    = requant(bus.mac_result);
    assign do_copy = (state == IDLE) && (commit_pend || bus.coef_commit);

    always_comb begin
        for (int i = 0; i < NCOEF; i++) shadow_nxt[i] = shadow[i];
        if (bus.coef_we && (int'(bus.coef_addr) < NCOEF))
            shadow_nxt[bus.coef_addr] = bus.coef_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.mac_a   = '0;
        bus.mac_b   = '0;
        bus.mac_ce  = 1'b0;
        bus.mac_clr = 1'b0;
        case (state)
            IDLE: if (bus.sample_valid) state_nxt = ISSUE;
            ISSUE: begin
                bus.mac_ce  = 1'b1;
                bus.mac_clr = (op_cnt == 3'd0);
                case (op_cnt)
                    3'd0: begin bus.mac_a = active[cidx];          bus.mac_b = x_cur;              end
                    3'd1: begin bus.mac_a = active[cidx];          bus.mac_b = x1_h[ch_r][stage]; end
                    3'd2: begin bus.mac_a = active[cidx];          bus.mac_b = x2_h[ch_r][stage]; end
                    3'd3: begin bus.mac_a = neg_sat(active[cidx]); bus.mac_b = y1_h[ch_r][stage]; end
                    default: begin bus.mac_a = neg_sat(active[cidx]); bus.mac_b = y2_h[ch_r][stage]; end
                endcase
                if (op_cnt == 3'd4) state_nxt = DRAIN;
            end
            DRAIN: if (drn_cnt == LAST_DRN) state_nxt = WB;
            WB:    state_nxt = (stage == LAST_STG) ? OUT : ISSUE;
            OUT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Coefficient banks: writes land in shadow, the copy waits for an IDLE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_pend <= 1'b0;
            for (int i = 0; i < NCOEF; i++) begin
                shadow[i] <= (i % 5 == 0) ? UNITY : '0;
                active[i] <= (i % 5 == 0) ? UNITY : '0;
            end
        end else begin
            for (int i = 0; i < NCOEF; i++) shadow[i] <= shadow_nxt[i];
            if (do_copy) begin
                for (int i = 0; i < NCOEF; i++) active[i] <= shadow_nxt[i];
                commit_pend <= 1'b0;
            end else if (bus.coef_commit) begin
                commit_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_cnt       <= '0;
            drn_cnt      <= '0;
            stage        <= '0;
            ch_r         <= 1'b0;
            x_cur        <= '0;
            y_last       <= '0;
            out_valid_r  <= 1'b0;
            out_ch_r     <= 1'b0;
            out_sample_r <= '0;
            overrun_r    <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                for (int s = 0; s < NUM_STAGES; s++) begin
                    x1_h[c][s] <= '0;
                    x2_h[c][s] <= '0;
                    y1_h[c][s] <= '0;
                    y2_h[c][s] <= '0;
                end
            end
        end else begin
            out_valid_r <= (state == OUT);
            if (bus.sample_valid && (state != IDLE)) overrun_r <= 1'b1;
            case (state)
                IDLE: if (bus.sample_valid) begin
                    x_cur  <= bus.sample_in;
                    ch_r   <= bus.sample_ch;
                    stage  <= '0;
                    op_cnt <= '0;
                end
                ISSUE: begin
                    op_cnt  <= op_cnt + 3'd1;
                    drn_cnt <= '0;
                end
                DRAIN: drn_cnt <= drn_cnt + DRN_W'(1);
                WB: begin
                    x2_h[ch_r][stage] <= x1_h[ch_r][stage];
                    x1_h[ch_r][stage] <= x_cur;
                    y2_h[ch_r][stage] <= y1_h[ch_r][stage];
                    y1_h[ch_r][stage] <= y_wb;
                    x_cur  <= y_wb;
                    y_last <= y_wb;
                    op_cnt <= '0;
                    if (stage != LAST_STG) stage <= stage + STG_W'(1);
                end
                OUT: begin
                    out_sample_r <= y_last;
                    out_ch_r     <= ch_r;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.out_ch     = out_ch_r;
    assign bus.out_sample = out_sample_r;
    assign bus.overrun    = overrun_r;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_biquad_cascade_sched.sv
// Bench for biquad_cascade_sched: directed vector tables, hand-written corner
// sequences and randomized samples against a plain-arithmetic cascade model.
module tb_biquad_cascade_sched;
    localparam int NS  = 4;
    localparam int ML  = 2;
    localparam int NC  = NS * 5;
    localparam int LAT = 1 + NS * (6 + ML);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    biquad_cascade_sched_if #(.NUM_STAGES(NS)) bus ();
    biquad_cascade_sched #(.NUM_STAGES(NS), .MAC_LAT(ML)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // External MAC: accumulator register followed by ML-1 delay registers.
    logic signed [31:0] mac_pipe [ML] = '{default: '0};
    always @(posedge clk) begin
        if (bus.mac_ce)
            mac_pipe[0] <= bus.mac_clr ? 32'(bus.mac_a * bus.mac_b)
                                       : mac_pipe[0] + 32'(bus.mac_a * bus.mac_b);
        for (int i = 1; i < ML; i++) mac_pipe[i] <= mac_pipe[i-1];
    end
    assign bus.mac_result = mac_pipe[ML-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.sample_valid = 1'b0;
        bus.sample_ch    = 1'b0;
        bus.sample_in    = '0;
        bus.coef_we      = 1'b0;
        bus.coef_addr    = '0;
        bus.coef_wdata   = '0;
        bus.coef_commit  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic write_coef(input int addr, input int val, input bit with_commit);
        bus.coef_we     = 1'b1;
        bus.coef_addr   = 5'(addr);
        bus.coef_wdata  = 16'(val);
        bus.coef_commit = with_commit;
        tick();
        bus.coef_we     = 1'b0;
        bus.coef_commit = 1'b0;
    endtask

    task automatic commit();
        bus.coef_commit = 1'b1;
        tick();
        bus.coef_commit = 1'b0;
    endtask

    // Send one sample while idle and wait (bounded) for its output strobe.
    task automatic run_sample(input int ch, input int x, output int y, output int yc,
                              output int lat, output int ce, output int clr, output int leak);
        bus.sample_valid = 1'b1;
        bus.sample_ch    = 1'(ch);
        bus.sample_in    = 16'(x);
        tick();
        bus.sample_valid = 1'b0;
        lat = 0; ce = 0; clr = 0; leak = 0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.mac_ce) ce++;
            if (bus.mac_ce && bus.mac_clr) clr++;
            if (!bus.mac_ce && (bus.mac_a != 0 || bus.mac_b != 0)) leak++;
            tick();
            lat++;
        end
        y  = bus.out_sample;
        yc = bus.out_ch;
    endtask

    // Reference model: direct-form-I cascade with plain integer arithmetic.
    int m_sh [NC];
    int m_act[NC];
    int mx1[2][NS], mx2[2][NS], my1[2][NS], my2[2][NS];

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) begin
            m_sh[i]  = (i % 5 == 0) ? 16384 : 0;
            m_act[i] = m_sh[i];
        end
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < NS; s++) begin
                mx1[c][s] = 0; mx2[c][s] = 0; my1[c][s] = 0; my2[c][s] = 0;
            end
    endfunction

    function automatic int m_neg(input int c);
        return (c == -32768) ? 32767 : -c;
    endfunction

    function automatic int m_requant(input int acc);
        shortint t;
`ifdef BIQUAD_SAT_EN
        if (acc >= (1 << 29)) return 32767;
        if (acc < -(1 << 29)) return -32768;
`endif
        t = shortint'(acc >>> 14);
        return int'(t);
    endfunction

    function automatic int model_step(input int ch, input int x);
        int v;
        v = x;
        for (int s = 0; s < NS; s++) begin
            longint acc;
            int b, y;
            b = s * 5;
            acc = longint'(m_act[b]) * v + longint'(m_act[b+1]) * mx1[ch][s]
                + longint'(m_act[b+2]) * mx2[ch][s]
                + longint'(m_neg(m_act[b+3])) * my1[ch][s]
                + longint'(m_neg(m_act[b+4])) * my2[ch][s];
            y = m_requant(int'(acc));
            mx2[ch][s] = mx1[ch][s]; mx1[ch][s] = v;
            my2[ch][s] = my1[ch][s]; my1[ch][s] = y;
            v = y;
        end
        return v;
    endfunction

    typedef struct {
        int ch;
        int x;
        int y;
    } vec_t;

    vec_t pt  [4];
    vec_t iso [3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int y, yc, lat, ce, clr, leak, pulses, pcyc, pval, pch, exp;

        pt[0]  = '{0, 1000, 1000};
        pt[1]  = '{1, -32768, -32768};
        pt[2]  = '{0, 32767, 32767};
        pt[3]  = '{1, -1, -1};
        iso[0] = '{0, 100, 0};
        iso[1] = '{1, 200, 0};
        iso[2] = '{0, 300, 100};

        clear_inputs();
        #3 reset = 1'b0;
        tick();
        check("rst_mac_ce", bus.mac_ce, 0);
        check("rst_mac_clr", bus.mac_clr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_out_ch", bus.out_ch, 0);
        check("rst_out_sample", bus.out_sample, 0);
        check("rst_mac_a", bus.mac_a, 0);
        check("rst_mac_b", bus.mac_b, 0);
        reset = 1'b1;
        tick();

        // Passthrough after reset
        for (int i = 0; i < 4; i++) begin
            run_sample(pt[i].ch, pt[i].x, y, yc, lat, ce, clr, leak);
            check($sformatf("pass%0d_latency", i), lat, LAT);
            check($sformatf("pass%0d_sample", i), y, pt[i].y);
            check($sformatf("pass%0d_ch", i), yc, pt[i].ch);
            check($sformatf("pass%0d_mac_ce_cycles", i), ce, 5 * NS);
            check($sformatf("pass%0d_mac_clr_cycles", i), clr, NS);
            check($sformatf("pass%0d_operand_leak", i), leak, 0);
            tick();
            check($sformatf("pass%0d_strobe_width", i), bus.out_valid, 0);
        end

        // Gain of one half in stage 0
        write_coef(0, 8192, 1'b0);
        commit();
        run_sample(0, 1000, y, yc, lat, ce, clr, leak);
        check("gain_sample", y, 500);

        // Channel isolation with a one-sample delay in stage 0
        do_reset();
        write_coef(0, 0, 1'b0);
        write_coef(1, 16384, 1'b0);
        commit();
        for (int i = 0; i < 3; i++) begin
            run_sample(iso[i].ch, iso[i].x, y, yc, lat, ce, clr, leak);
            check($sformatf("iso%0d_sample", i), y, iso[i].y);
            check($sformatf("iso%0d_ch", i), yc, iso[i].ch);
        end

        // Overrun: second strobe 10 cycles into the computation is dropped
        do_reset();
        bus.sample_valid = 1'b1; bus.sample_ch = 1'b0; bus.sample_in = 16'sd1000;
        tick();
        bus.sample_valid = 1'b0;
        pulses = 0; pcyc = -1; pval = 0; pch = 0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (cyc == 10) begin
                check("ovr_before", bus.overrun, 0);
                bus.sample_valid = 1'b1; bus.sample_ch = 1'b1; bus.sample_in = 16'sd5555;
            end
            tick();
            bus.sample_valid = 1'b0;
            if (bus.out_valid) begin
                pulses++;
                if (pcyc < 0) begin pcyc = cyc; pval = bus.out_sample; pch = bus.out_ch; end
            end
        end
        check("ovr_pulses", pulses, 1);
        check("ovr_latency", pcyc, LAT);
        check("ovr_sample", pval, 1000);
        check("ovr_ch", pch, 0);
        check("ovr_sticky", bus.overrun, 1);
        do_reset();
        check("ovr_cleared", bus.overrun, 0);

        // Commit during a computation takes effect on the next sample
        bus.sample_valid = 1'b1; bus.sample_ch = 1'b0; bus.sample_in = 16'sd1000;
        tick();
        bus.sample_valid = 1'b0;
        repeat (4) tick();
        write_coef(0, 8192, 1'b1);
        lat = 5;
        while (!bus.out_valid && lat < 200) begin tick(); lat++; end
        check("cmt_latency", lat, LAT);
        check("cmt_old_coef", bus.out_sample, 1000);
        run_sample(0, 1000, y, yc, lat, ce, clr, leak);
        check("cmt_new_coef", y, 500);
        write_coef(0, 16384, 1'b1);
        run_sample(0, 1000, y, yc, lat, ce, clr, leak);
        check("cmt_write_in_copy", y, 1000);

        // Stage overflow
        do_reset();
        write_coef(0, 32767, 1'b1);
        run_sample(0, 20000, y, yc, lat, ce, clr, leak);
`ifdef BIQUAD_SAT_EN
        check("overflow_sat", y, 32767);
`else
        check("overflow_wrap", y, -25538);
`endif

        // Asynchronous reset in the middle of ISSUE
        bus.sample_valid = 1'b1; bus.sample_ch = 1'b1; bus.sample_in = 16'sd1234;
        tick();
        bus.sample_valid = 1'b0;
        tick();
        check("midrst_in_issue", bus.mac_ce, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_mac_ce", bus.mac_ce, 0);
        check("midrst_mac_a", bus.mac_a, 0);
        check("midrst_mac_b", bus.mac_b, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_out_sample", bus.out_sample, 0);
        check("midrst_out_ch", bus.out_ch, 0);
        tick();
        reset = 1'b1;
        pulses = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        check("midrst_no_output", pulses, 0);
        run_sample(1, 777, y, yc, lat, ce, clr, leak);
        check("midrst_passthrough_restored", y, 777);

        // Randomized samples and coefficient sets against the model
        do_reset();
        model_reset();
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < NC; i++) begin
                int v;
                v = (round == 0) ? int'($urandom_range(0, 32767)) - 16384
                                 : int'(shortint'($urandom));
                if (round == 2 && i == 8) v = -32768;
                write_coef(i, v, 1'b0);
                m_sh[i] = v;
            end
            write_coef(NC + 5, 1234, 1'b0);
            commit();
            for (int i = 0; i < NC; i++) m_act[i] = m_sh[i];
            for (int n = 0; n < 12; n++) begin
                int ch, x;
                ch  = int'($urandom_range(0, 1));
                x   = int'(shortint'($urandom));
                exp = model_step(ch, x);
                run_sample(ch, x, y, yc, lat, ce, clr, leak);
                check($sformatf("rnd%0d_%0d_sample", round, n), y, exp);
                check($sformatf("rnd%0d_%0d_ch", round, n), yc, ch);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
